// File: rtl/seg7_scan.sv
// Scanned 8-digit seven-segment driver with frame-coherent value updates.
// Optional leading-zero blanking: define SEG7_LZ_SUPPRESS_EN.
module seg7_scan #(
    parameter int NDIGITS   = 8,
    parameter int CLK_DIV   = 262144,
    parameter int BLANK_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   data,
    input  logic                   upd_req,
    input  logic [NDIGITS-1:0]     dp_mask,
    output logic                   upd_ack,
    output logic                   frame_done,
    output logic [NDIGITS-1:0]     an,
    output logic [6:0]             seg,
    output logic                   dp
);

    localparam int DW = 4 * NDIGITS;
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     staging_q, staging_d;
    logic [DW-1:0]     shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [NDIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              wrap;
    logic              boundary;
    logic              ack;
    logic              show;
    logic [3:0]        nib;

    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign wrap     = (cnt_q == CNT_LAST);
    assign boundary = wrap && (idx_q == IDX_LAST);
    assign ack      = boundary && pending_q;

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANK: if (cnt_d >= BLANK_END) state_d = DRIVE;
            DRIVE: if (wrap && BLANK_CYC > 0) state_d = BLANK;
        endcase
    end

    // A request on the boundary cycle refills staging after the old
    // staged word has moved to shadow, so pending stays set.
    always_comb begin
        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (ack) begin
            shadow_d  = staging_q;
            pending_d = 1'b0;
        end
        if (upd_req) begin
            staging_d = data;
            pending_d = 1'b1;
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [IW-1:0] top;

    always_comb begin
        top = '0;
        for (int k = 1; k < NDIGITS; k++) begin
            if (shadow_q[4*k +: 4] != 4'h0) top = IW'(k);
        end
    end

    assign show = (idx_q <= top);
`else
    assign show = 1'b1;
`endif

    assign nib = shadow_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (state_q == DRIVE) begin
            dp_d = ~dp_mask[idx_q];
            if (show) begin
                an_d  = ~(NDIGITS'(1) << idx_q);
                seg_d = seg7_decode(nib);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= '1;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign upd_ack    = ack;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan against a frame-level display model.
// Honours SEG7_LZ_SUPPRESS_EN the same way the design does.
module tb_seg7_scan;

    localparam int N  = 8;
    localparam int CD = 4;
    localparam int BC = 1;
    localparam int F  = N * CD;

`ifdef SEG7_LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic        upd_req;
    logic [7:0]  dp_mask;
    logic        upd_ack;
    logic        frame_done;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan #(
        .NDIGITS  (N),
        .CLK_DIV  (CD),
        .BLANK_CYC(BC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .upd_req   (upd_req),
        .dp_mask   (dp_mask),
        .upd_ack   (upd_ack),
        .frame_done(frame_done),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n_vec;
    int          n_err;
    int          m_c;
    logic [31:0] m_stage;
    logic [31:0] m_shadow;
    bit          m_pend;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [7:0]  cur_mask;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h",
                     tag, m_c, got, exp);
        end
    endtask

    // Check the current cycle, apply this cycle's inputs, advance the model.
    task automatic tick(input bit req, input logic [31:0] d,
                        input logic [7:0] m);
        bit bnd;
        int p, dg, top;
        logic [3:0] nv;
        bnd = (m_c % F) == F - 1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(bnd));
        check("upd_ack", 32'(upd_ack), 32'(bnd && m_pend));
        upd_req = req;
        data    = d;
        dp_mask = m;
        p  = m_c % CD;
        dg = (m_c / CD) % N;
        e_an  = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (m_c != 0 && p >= BC) begin
            e_dp = ~m[dg];
            top = 0;
            for (int k = 1; k < N; k++)
                if (((m_shadow >> (4 * k)) & 32'hF) != 0) top = k;
            if (!LZ || dg <= top) begin
                nv    = 4'((m_shadow >> (4 * dg)) & 32'hF);
                e_an  = 8'hFF ^ (8'h01 << dg);
                e_seg = SEG[nv];
            end
        end
        if (bnd && m_pend) begin
            m_shadow = m_stage;
            m_pend   = 1'b0;
        end
        if (req) begin
            m_stage = d;
            m_pend  = 1'b1;
        end
        m_c++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom, cur_mask);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        upd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_an", 32'(an), 32'hFF);
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_dp", 32'(dp), 32'h1);
            check("rst_ack", 32'(upd_ack), 32'h0);
            check("rst_fd", 32'(frame_done), 32'h0);
        end
        reset    = 1'b0;
        m_c      = 0;
        m_stage  = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        e_an     = 8'hFF;
        e_seg    = 7'h7F;
        e_dp     = 1'b1;
    endtask

    initial begin
        int guard;
        clk      = 1'b0;
        reset    = 1'b1;
        data     = '0;
        upd_req  = 1'b0;
        dp_mask  = '0;
        cur_mask = '0;
        n_vec    = 0;
        n_err    = 0;
        m_c      = 0;

        do_reset();

        tick(1'b1, 32'h0123_4567, cur_mask);
        idle(2 * F + 3);

        idle(F / 2 - (m_c % F) + F);
        tick(1'b1, 32'hDEAD_BEEF, cur_mask);
        idle(2 * F);

        while ((m_c % F) != F - 4) tick(1'b0, '0, cur_mask);
        tick(1'b1, 32'hAAAA_AAAA, cur_mask);
        while ((m_c % F) != F - 1) tick(1'b0, '0, cur_mask);
        tick(1'b1, 32'hBBBB_BBBB, cur_mask);
        idle(3 * F);

        cur_mask = 8'h04;
        idle(F);

        tick(1'b1, 32'h0000_00A5, cur_mask);
        idle(2 * F);
        tick(1'b1, 32'h0000_0000, cur_mask);
        idle(2 * F);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) cur_mask = 8'($urandom);
            tick($urandom_range(0, 19) == 0,
                 $urandom >> $urandom_range(0, 32), cur_mask);
        end

        guard = 0;
        while (e_an == 8'hFF && guard < 40) begin
            tick(1'b0, '0, cur_mask);
            guard++;
        end
        check("drive_seen", 32'(e_an != 8'hFF), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_an", 32'(an), 32'hFF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) cur_mask = 8'($urandom);
            tick($urandom_range(0, 9) == 0,
                 $urandom >> $urandom_range(0, 32), cur_mask);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
